// File: rtl/axis_joiner.sv
// axis_joiner: each header packet on axis_i1 is followed by one payload packet on axis_i2 as a single output packet.
// Optional registered output (2-entry skid buffer) selected by defining AXIS_JOINER_OUTPUT_REG_EN.
module axis_joiner #(
    parameter int unsigned AXIS_BYTES     = 1,
    parameter int unsigned AXIS_USER_BITS = 1,
    parameter int unsigned HDR_WORDS      = 0
) (
    input  logic                        clk,
    input  logic                        sresetn,
    input  logic [8*AXIS_BYTES-1:0]     axis_i1_tdata,
    input  logic [AXIS_BYTES-1:0]       axis_i1_tkeep,
    input  logic [AXIS_USER_BITS-1:0]   axis_i1_tuser,
    input  logic                        axis_i1_tlast,
    input  logic                        axis_i1_tvalid,
    output logic                        axis_i1_tready,
    input  logic [8*AXIS_BYTES-1:0]     axis_i2_tdata,
    input  logic [AXIS_BYTES-1:0]       axis_i2_tkeep,
    input  logic [AXIS_USER_BITS-1:0]   axis_i2_tuser,
    input  logic                        axis_i2_tlast,
    input  logic                        axis_i2_tvalid,
    output logic                        axis_i2_tready,
    output logic [8*AXIS_BYTES-1:0]     axis_o_tdata,
    output logic [AXIS_BYTES-1:0]       axis_o_tkeep,
    output logic [AXIS_USER_BITS-1:0]   axis_o_tuser,
    output logic                        axis_o_tlast,
    output logic                        axis_o_tvalid,
    input  logic                        axis_o_tready,
    output logic                        hdr_err
);

    localparam int unsigned DATA_W   = 8 * AXIS_BYTES;
    localparam int unsigned CTR_W    = ($clog2(HDR_WORDS + 2) > 1) ? $clog2(HDR_WORDS + 2) : 1;
    localparam logic [CTR_W-1:0] CTR_SAT  = CTR_W'(HDR_WORDS + 1);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(HDR_WORDS - 1);

    typedef struct packed {
        logic [DATA_W-1:0]         tdata;
        logic [AXIS_BYTES-1:0]     tkeep;
        logic [AXIS_USER_BITS-1:0] tuser;
        logic                      tlast;
    } beat_t;

    typedef enum logic {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             hdr_err_q, hdr_err_d;
    beat_t            mux_beat;
    logic             mux_valid;
    logic             o_ready_int;

    // State, header beat counter and error pulse register
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q   <= ST_HDR;
            ctr_q     <= '0;
            hdr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            hdr_err_q <= hdr_err_d;
        end
    end

    // Source select, ready steering and next state; treadys held low during reset
    always_comb begin
        state_d        = state_q;
        ctr_d          = ctr_q;
        hdr_err_d      = 1'b0;
        mux_beat       = '0;
        mux_valid      = 1'b0;
        axis_i1_tready = 1'b0;
        axis_i2_tready = 1'b0;
        case (state_q)
            ST_HDR: begin
                mux_beat       = '{tdata: axis_i1_tdata, tkeep: axis_i1_tkeep,
                                   tuser: axis_i1_tuser, tlast: 1'b0};
                mux_valid      = axis_i1_tvalid & sresetn;
                axis_i1_tready = o_ready_int & sresetn;
                if (axis_i1_tvalid && axis_i1_tready) begin
                    if (ctr_q != CTR_SAT) begin
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                    if (axis_i1_tlast) begin
                        state_d   = ST_PAYLOAD;
                        ctr_d     = '0;
                        hdr_err_d = (HDR_WORDS != 0) && (ctr_q != CTR_LAST);
                    end
                end
            end
            ST_PAYLOAD: begin
                mux_beat       = '{tdata: axis_i2_tdata, tkeep: axis_i2_tkeep,
                                   tuser: axis_i2_tuser, tlast: axis_i2_tlast};
                mux_valid      = axis_i2_tvalid & sresetn;
                axis_i2_tready = o_ready_int & sresetn;
                if (axis_i2_tvalid && axis_i2_tready && axis_i2_tlast) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    assign hdr_err = hdr_err_q;

`ifdef AXIS_JOINER_OUTPUT_REG_EN
    logic  out_valid_q, skid_valid_q;
    beat_t out_q, skid_q;

    // Upstream ready depends only on skid occupancy, never on axis_o_tready
    assign o_ready_int = ~skid_valid_q;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (!out_valid_q || axis_o_tready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_q       <= mux_beat;
                out_valid_q <= mux_valid;
            end
        end else if (mux_valid && o_ready_int) begin
            skid_q       <= mux_beat;
            skid_valid_q <= 1'b1;
        end
    end

    assign axis_o_tvalid = out_valid_q;
    assign axis_o_tdata  = out_q.tdata;
    assign axis_o_tkeep  = out_q.tkeep;
    assign axis_o_tuser  = out_q.tuser;
    assign axis_o_tlast  = out_q.tlast;
`else
    assign o_ready_int   = axis_o_tready;
    assign axis_o_tvalid = mux_valid;
    assign axis_o_tdata  = mux_beat.tdata;
    assign axis_o_tkeep  = mux_beat.tkeep;
    assign axis_o_tuser  = mux_beat.tuser;
    assign axis_o_tlast  = mux_beat.tlast;
`endif

endmodule

// File: tb/tb_axis_joiner.sv
// Self-checking bench for axis_joiner: random traffic against a packet-level concatenation model.
module tb_axis_joiner;

    localparam int unsigned AB = 2;
    localparam int unsigned UB = 2;
    localparam int unsigned HW = 2;
`ifdef AXIS_JOINER_OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [8*AB-1:0] d;
        logic [AB-1:0]   k;
        logic [UB-1:0]   u;
        logic            l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  sresetn;
    beat_t i1b, i2b;
    logic  i1v, i2v, o_rdy;

    logic            axis_i1_tready, axis_i2_tready;
    logic [8*AB-1:0] axis_o_tdata;
    logic [AB-1:0]   axis_o_tkeep;
    logic [UB-1:0]   axis_o_tuser;
    logic            axis_o_tlast, axis_o_tvalid, hdr_err;

    axis_joiner #(.AXIS_BYTES(AB), .AXIS_USER_BITS(UB), .HDR_WORDS(HW)) dut (
        .clk(clk), .sresetn(sresetn),
        .axis_i1_tdata(i1b.d), .axis_i1_tkeep(i1b.k), .axis_i1_tuser(i1b.u),
        .axis_i1_tlast(i1b.l), .axis_i1_tvalid(i1v), .axis_i1_tready(axis_i1_tready),
        .axis_i2_tdata(i2b.d), .axis_i2_tkeep(i2b.k), .axis_i2_tuser(i2b.u),
        .axis_i2_tlast(i2b.l), .axis_i2_tvalid(i2v), .axis_i2_tready(axis_i2_tready),
        .axis_o_tdata(axis_o_tdata), .axis_o_tkeep(axis_o_tkeep), .axis_o_tuser(axis_o_tuser),
        .axis_o_tlast(axis_o_tlast), .axis_o_tvalid(axis_o_tvalid), .axis_o_tready(o_rdy),
        .hdr_err(hdr_err)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t h_q[$], p_q[$], exp_q[$];
    int    hcnt = 0;
    logic  err_exp = 1'b0;
    int    err_pulses, bubbles, first_in, first_out, i2_hs_cnt;

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        b.d = 16'($urandom);
        b.k = 2'($urandom);
        b.u = 2'($urandom);
        b.l = last;
        return b;
    endfunction

    // Expected output of a packet is the header with tlast cleared, then the payload verbatim
    task automatic add_pkt(input int hl, input int pl);
        beat_t b;
        for (int i = 0; i < hl; i++) begin
            b = rnd_beat(i == hl - 1);
            h_q.push_back(b);
            b.l = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < pl; i++) begin
            b = rnd_beat(i == pl - 1);
            p_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic run(input int budget, input int p1, input int p2, input int pr, input int stop_i2);
        int    cyc;
        logic  stall_prev, h1, h2;
        beat_t prev_o, cur_o, e;
        cyc = 0; stall_prev = 1'b0; prev_o = '0;
        bubbles = 0; first_in = -1; first_out = -1; i2_hs_cnt = 0; err_pulses = 0;
        while (1) begin
            @(negedge clk);
            cur_o.d = axis_o_tdata; cur_o.k = axis_o_tkeep;
            cur_o.u = axis_o_tuser; cur_o.l = axis_o_tlast;
            if (stall_prev) begin
                checks++;
                if (axis_o_tvalid !== 1'b1 || cur_o !== prev_o) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h, need v=1 %h", axis_o_tvalid, cur_o, prev_o);
                end
            end
            if (axis_o_tvalid && first_out < 0) first_out = cyc;
            if (i1v && first_in < 0) first_in = cyc;
            if (first_out >= 0 && exp_q.size() > 0 && !axis_o_tvalid) bubbles++;
            if (axis_o_tvalid && o_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got unexpected %h, need no beat", cur_o);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_o !== e) begin
                        errors++;
                        $display("FAIL out_beat: got %h, need %h", cur_o, e);
                    end
                end
            end
            checks++;
            if (hdr_err !== err_exp) begin
                errors++;
                $display("FAIL hdr_err: got %b, need %b (cycle %0d)", hdr_err, err_exp, cyc);
            end
            if (hdr_err === 1'b1) err_pulses++;
            checks++;
            if (axis_i1_tready && axis_i2_tready) begin
                errors++;
                $display("FAIL one_ready: got both treadys 1, need at most one");
            end
            h1 = i1v && axis_i1_tready;
            h2 = i2v && axis_i2_tready;
            err_exp = 1'b0;
            if (h1) begin
                hcnt++;
                if (i1b.l) begin
                    err_exp = (hcnt != int'(HW));
                    hcnt = 0;
                end
            end
            if (h2) i2_hs_cnt++;
            stall_prev = axis_o_tvalid && !o_rdy;
            prev_o = cur_o;
            @(posedge clk);
            #1;
            cyc++;
            if (h1) i1v = 1'b0;
            if (h2) i2v = 1'b0;
            if (!i1v && h_q.size() > 0 && int'($urandom_range(99)) < p1) begin
                i1b = h_q.pop_front();
                i1v = 1'b1;
            end
            if (!i2v && p_q.size() > 0 && int'($urandom_range(99)) < p2) begin
                i2b = p_q.pop_front();
                i2v = 1'b1;
            end
            o_rdy = (int'($urandom_range(99)) < pr);
            if (stop_i2 > 0 && i2_hs_cnt >= stop_i2) break;
            if (h_q.size() == 0 && p_q.size() == 0 && !i1v && !i2v && exp_q.size() == 0) break;
            if (cyc >= budget) begin
                errors++;
                $display("FAIL timeout: got %0d beats outstanding after %0d cycles, need 0", exp_q.size(), cyc);
                break;
            end
        end
    endtask

    task automatic test_reset();
        sresetn = 1'b0; o_rdy = 1'b1;
        i1b = rnd_beat(1'b0); i1v = 1'b1;
        i2b = rnd_beat(1'b1); i2v = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (axis_o_tvalid !== 1'b0 || hdr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v=%b err=%b, need 0 0", axis_o_tvalid, hdr_err);
        end
        checks++;
        if (axis_i1_tready !== 1'b0 || axis_i2_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b, need 00", axis_i1_tready, axis_i2_tready);
        end
        sresetn = 1'b1;
        #1;
        checks++;
        if (axis_i1_tready !== 1'b1 || axis_i2_tready !== 1'b0) begin
            errors++;
            $display("FAIL hdr_state_ready: got i1=%b i2=%b, need 1 0", axis_i1_tready, axis_i2_tready);
        end
        checks++;
        if (axis_o_tvalid !== (LAT == 0)) begin
            errors++;
            $display("FAIL out_latency0: got v=%b, need %b", axis_o_tvalid, LAT == 0);
        end
        i1v = 1'b0; i2v = 1'b0;
    endtask

    task automatic test_basic();
        add_pkt(2, 3);
        run(200, 100, 100, 100, 0);
        checks++;
        if (err_pulses != 0) begin
            errors++;
            $display("FAIL basic_no_err: got %0d pulses, need 0", err_pulses);
        end
    endtask

    task automatic test_hdr_err();
        add_pkt(3, 2);
        run(200, 100, 100, 100, 0);
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL long_hdr_err: got %0d pulses, need 1", err_pulses);
        end
        add_pkt(1, 2);
        run(200, 70, 70, 60, 0);
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL short_hdr_err: got %0d pulses, need 1", err_pulses);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 100; n++) begin
            add_pkt(int'($urandom_range(16, 1)), int'($urandom_range(16, 1)));
        end
        run(40000, 60, 90, 50, 0);
    endtask

    task automatic test_mid_reset();
        add_pkt(2, 3);
        run(200, 100, 100, 100, 1);
        sresetn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (axis_o_tvalid !== 1'b0 || axis_i1_tready !== 1'b0 || axis_i2_tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b rdy=%b%b, need 0 00", axis_o_tvalid, axis_i1_tready, axis_i2_tready);
        end
        sresetn = 1'b1;
        h_q.delete(); p_q.delete(); exp_q.delete();
        hcnt = 0; err_exp = 1'b0;
        i1v = 1'b0; i2b = rnd_beat(1'b1); i2v = 1'b1; o_rdy = 1'b1;
        #1;
        checks++;
        if (axis_i2_tready !== 1'b0 || axis_i1_tready !== 1'b1) begin
            errors++;
            $display("FAIL restart_hdr: got i1=%b i2=%b, need 1 0", axis_i1_tready, axis_i2_tready);
        end
        i2v = 1'b0;
        add_pkt(2, 2);
        run(200, 80, 80, 70, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) add_pkt(1, 1);
        run(200, 100, 100, 100, 0);
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL throughput: got %0d idle cycles, need 0", bubbles);
        end
        checks++;
        if (first_out - first_in != LAT) begin
            errors++;
            $display("FAIL latency: got %0d, need %0d", first_out - first_in, LAT);
        end
        checks++;
        if (err_pulses != 8) begin
            errors++;
            $display("FAIL b2b_err: got %0d pulses, need 8", err_pulses);
        end
    endtask

    initial begin
        i1b = '0; i2b = '0; i1v = 1'b0; i2v = 1'b0; o_rdy = 1'b0; sresetn = 1'b0;
        test_reset();
        test_basic();
        test_hdr_err();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
